// File: rtl/mc_control_fsm_if.sv
// Control bundle between the multi-cycle sequencer (master) and the datapath (slave):
// instruction fields and status flow in, mux selects and enables flow out.
interface mc_control_fsm_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;

    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       ext_zero;
    logic [1:0] pc_source;
    logic [3:0] alu_op;
    logic       illegal_op;

    modport master (
        input  opcode, funct, zero, mem_ready,
        output pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
               reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, ext_zero,
               pc_source, alu_op, illegal_op
    );

    modport slave (
        output opcode, funct, zero, mem_ready,
        input  pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
               reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, ext_zero,
               pc_source, alu_op, illegal_op
    );
endinterface

// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS control sequencer (fetch/decode/execute/memory/write-back).
// Optional macro IMM_LOGIC_EN adds andi/ori/xori through the immediate path.
module mc_control_fsm (
    input  logic             clk,
    input  logic             rst_n,
    mc_control_fsm_if.master bus
);

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEM_ADDR = 4'd2;
    localparam logic [3:0] S_MEM_RD   = 4'd3;
    localparam logic [3:0] S_MEM_WB   = 4'd4;
    localparam logic [3:0] S_MEM_WR   = 4'd5;
    localparam logic [3:0] S_R_EXEC   = 4'd6;
    localparam logic [3:0] S_R_WB     = 4'd7;
    localparam logic [3:0] S_I_EXEC   = 4'd8;
    localparam logic [3:0] S_I_WB     = 4'd9;
    localparam logic [3:0] S_BRANCH   = 4'd10;
    localparam logic [3:0] S_JUMP     = 4'd11;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
`ifdef IMM_LOGIC_EN
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
`endif

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_SLT = 4'b0010;
    localparam logic [3:0] ALU_AND = 4'b0100;
    localparam logic [3:0] ALU_OR  = 4'b0101;
    localparam logic [3:0] ALU_XOR = 4'b0110;
    localparam logic [3:0] ALU_NOR = 4'b0111;

    logic [3:0] state_q, state_d;
    logic       run_q, run_d;

    // Returns {legal, alu_op} for an R-type funct field.
    function automatic logic [4:0] r_decode(input logic [5:0] f);
        case (f)
            6'h20:   r_decode = {1'b1, ALU_ADD};
            6'h22:   r_decode = {1'b1, ALU_SUB};
            6'h24:   r_decode = {1'b1, ALU_AND};
            6'h25:   r_decode = {1'b1, ALU_OR};
            6'h26:   r_decode = {1'b1, ALU_XOR};
            6'h27:   r_decode = {1'b1, ALU_NOR};
            6'h2A:   r_decode = {1'b1, ALU_SLT};
            default: r_decode = {1'b0, ALU_ADD};
        endcase
    endfunction

    // Returns {ext_zero, alu_op} for an immediate-format ALU instruction.
    function automatic logic [4:0] i_decode(input logic [5:0] op);
`ifdef IMM_LOGIC_EN
        case (op)
            OP_ANDI: i_decode = {1'b1, ALU_AND};
            OP_ORI:  i_decode = {1'b1, ALU_OR};
            OP_XORI: i_decode = {1'b1, ALU_XOR};
            default: i_decode = {1'b0, ALU_ADD};
        endcase
`else
        i_decode = (op == OP_ADDI) ? {1'b0, ALU_ADD} : {1'b0, ALU_ADD};
`endif
    endfunction

    // run_q holds the datapath quiet until the first clock edge after reset
    // release, so outputs are all-zero throughout reset regardless of state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
        end
    end

    assign run_d = 1'b1;

    always_comb begin
        logic [4:0] r_dec;
        logic [4:0] i_dec;

        r_dec = r_decode(bus.funct);
        i_dec = i_decode(bus.opcode);

        state_d            = state_q;
        bus.pc_write       = 1'b0;
        bus.pc_write_cond  = 1'b0;
        bus.iord           = 1'b0;
        bus.mem_read       = 1'b0;
        bus.mem_write      = 1'b0;
        bus.ir_write       = 1'b0;
        bus.reg_dst        = 1'b0;
        bus.mem_to_reg     = 1'b0;
        bus.reg_write      = 1'b0;
        bus.alu_src_a      = 1'b0;
        bus.alu_src_b      = 2'd0;
        bus.ext_zero       = 1'b0;
        bus.pc_source      = 2'd0;
        bus.alu_op         = ALU_ADD;
        bus.illegal_op     = 1'b0;

        if (run_q) begin
            case (state_q)
                S_FETCH: begin
                    bus.mem_read  = 1'b1;
                    bus.alu_src_b = 2'd1;
                    bus.ir_write  = bus.mem_ready;
                    bus.pc_write  = bus.mem_ready;
                    if (bus.mem_ready) state_d = S_DECODE;
                end
                S_DECODE: begin
                    // ALU precomputes the branch target into ALUOut here.
                    bus.alu_src_b = 2'd3;
                    case (bus.opcode)
                        OP_RTYPE:     state_d = S_R_EXEC;
                        OP_LW, OP_SW: state_d = S_MEM_ADDR;
                        OP_BEQ:       state_d = S_BRANCH;
                        OP_J:         state_d = S_JUMP;
                        OP_ADDI:      state_d = S_I_EXEC;
`ifdef IMM_LOGIC_EN
                        OP_ANDI, OP_ORI, OP_XORI: state_d = S_I_EXEC;
`endif
                        default: begin
                            bus.illegal_op = 1'b1;
                            state_d        = S_FETCH;
                        end
                    endcase
                end
                S_MEM_ADDR: begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_src_b = 2'd2;
                    state_d       = (bus.opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
                end
                S_MEM_RD: begin
                    bus.mem_read = 1'b1;
                    bus.iord     = 1'b1;
                    if (bus.mem_ready) state_d = S_MEM_WB;
                end
                S_MEM_WB: begin
                    bus.reg_write  = 1'b1;
                    bus.mem_to_reg = 1'b1;
                    state_d        = S_FETCH;
                end
                S_MEM_WR: begin
                    bus.mem_write = 1'b1;
                    bus.iord      = 1'b1;
                    if (bus.mem_ready) state_d = S_FETCH;
                end
                S_R_EXEC: begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_op    = r_dec[3:0];
                    if (r_dec[4]) begin
                        state_d = S_R_WB;
                    end else begin
                        bus.illegal_op = 1'b1;
                        state_d        = S_FETCH;
                    end
                end
                S_R_WB: begin
                    bus.reg_write = 1'b1;
                    bus.reg_dst   = 1'b1;
                    state_d       = S_FETCH;
                end
                S_I_EXEC: begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_src_b = 2'd2;
                    bus.ext_zero  = i_dec[4];
                    bus.alu_op    = i_dec[3:0];
                    state_d       = S_I_WB;
                end
                S_I_WB: begin
                    bus.reg_write = 1'b1;
                    state_d       = S_FETCH;
                end
                S_BRANCH: begin
                    bus.alu_src_a     = 1'b1;
                    bus.alu_op        = ALU_SUB;
                    bus.pc_write_cond = 1'b1;
                    bus.pc_source     = 2'd1;
                    state_d           = S_FETCH;
                end
                S_JUMP: begin
                    bus.pc_write  = 1'b1;
                    bus.pc_source = 2'd2;
                    state_d       = S_FETCH;
                end
                default: state_d = S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm: walks each instruction class state by state
// and compares the packed control word against hand-derived values.
module tb_mc_control_fsm;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_err;

    mc_control_fsm_if bus();

    mc_control_fsm dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [19:0] cw_obs;
    assign cw_obs = {bus.pc_write, bus.pc_write_cond, bus.iord, bus.mem_read,
                     bus.mem_write, bus.ir_write, bus.reg_dst, bus.mem_to_reg,
                     bus.reg_write, bus.alu_src_a, bus.alu_src_b, bus.ext_zero,
                     bus.pc_source, bus.alu_op, bus.illegal_op};

    function automatic logic [19:0] mk(
        input logic pcw, pcwc, iord, mrd, mwr, irw, rdst, m2r, rw, asa,
        input logic [1:0] asb, input logic ez, input logic [1:0] pcs,
        input logic [3:0] aop, input logic ill);
        mk = {pcw, pcwc, iord, mrd, mwr, irw, rdst, m2r, rw, asa, asb, ez, pcs, aop, ill};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock cycle: inputs set just after a rising edge, outputs checked at the falling edge.
    task automatic cyc(input string tag, input logic mr, input logic [19:0] exp);
        bus.mem_ready = mr;
        @(negedge clk);
        chk(tag, {12'd0, cw_obs}, {12'd0, exp});
        @(posedge clk);
        #1;
    endtask

    task automatic instr(input logic [5:0] op, input logic [5:0] fn);
        bus.opcode = op;
        bus.funct  = fn;
    endtask

    logic [19:0] W_FETCH_RDY, W_FETCH_WAIT, W_DECODE, W_DECODE_ILL, W_R_WB,
                 W_MEM_ADDR, W_MEM_RD, W_MEM_WB, W_MEM_WR, W_I_EXEC_ADD,
                 W_I_EXEC_ORI, W_I_WB, W_BRANCH, W_JUMP, W_R_ILL;

    logic [5:0] r_fn  [6];
    logic [3:0] r_aop [6];

    initial begin
        //                    pcw cnd io rd wr ir dst m2r rw a  b    ez pcs  aop      ill
        W_FETCH_RDY  = mk(1, 0, 0, 1, 0, 1, 0, 0, 0, 0, 2'd1, 0, 2'd0, 4'b0000, 0);
        W_FETCH_WAIT = mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 2'd1, 0, 2'd0, 4'b0000, 0);
        W_DECODE     = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd3, 0, 2'd0, 4'b0000, 0);
        W_DECODE_ILL = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd3, 0, 2'd0, 4'b0000, 1);
        W_R_WB       = mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 2'd0, 0, 2'd0, 4'b0000, 0);
        W_MEM_ADDR   = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd2, 0, 2'd0, 4'b0000, 0);
        W_MEM_RD     = mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 4'b0000, 0);
        W_MEM_WB     = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2'd0, 0, 2'd0, 4'b0000, 0);
        W_MEM_WR     = mk(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 4'b0000, 0);
        W_I_EXEC_ADD = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd2, 0, 2'd0, 4'b0000, 0);
        W_I_EXEC_ORI = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd2, 1, 2'd0, 4'b0101, 0);
        W_I_WB       = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'd0, 0, 2'd0, 4'b0000, 0);
        W_BRANCH     = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 2'd0, 0, 2'd1, 4'b0001, 0);
        W_JUMP       = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 0, 2'd2, 4'b0000, 0);
        W_R_ILL      = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd0, 0, 2'd0, 4'b0000, 1);

        r_fn[0] = 6'h20; r_aop[0] = 4'b0000;
        r_fn[1] = 6'h22; r_aop[1] = 4'b0001;
        r_fn[2] = 6'h24; r_aop[2] = 4'b0100;
        r_fn[3] = 6'h25; r_aop[3] = 4'b0101;
        r_fn[4] = 6'h26; r_aop[4] = 4'b0110;
        r_fn[5] = 6'h2A; r_aop[5] = 4'b0010;

        n_chk = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.opcode = 6'h00;
        bus.funct = 6'h00;
        bus.zero = 1'b0;
        bus.mem_ready = 1'b1;

        #1;
        chk("reset_outputs", {12'd0, cw_obs}, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("release_gap", {12'd0, cw_obs}, 32'd0);
        @(posedge clk); #1;

        // R-type nor, mem_ready tied high
        instr(6'h00, 6'h27);
        cyc("nor_fetch", 1, W_FETCH_RDY);
        cyc("nor_decode", 1, W_DECODE);
        cyc("nor_exec", 1, mk(0,0,0,0,0,0,0,0,0,1,2'd0,0,2'd0,4'b0111,0));
        cyc("nor_wb", 1, W_R_WB);

        // Remaining R-type functs
        for (int i = 0; i < 6; i++) begin
            instr(6'h00, r_fn[i]);
            cyc("r_fetch", 1, W_FETCH_RDY);
            cyc("r_decode", 1, W_DECODE);
            cyc($sformatf("r_exec_f%0h", r_fn[i]), 1,
                mk(0,0,0,0,0,0,0,0,0,1,2'd0,0,2'd0,r_aop[i],0));
            cyc("r_wb", 1, W_R_WB);
        end

        // lw with two wait states in MEM_RD; mem_ready low in DECODE/MEM_ADDR is ignored
        instr(6'h23, 6'h00);
        cyc("lw_fetch", 1, W_FETCH_RDY);
        cyc("lw_decode", 0, W_DECODE);
        cyc("lw_addr", 0, W_MEM_ADDR);
        cyc("lw_rd_w0", 0, W_MEM_RD);
        cyc("lw_rd_w1", 0, W_MEM_RD);
        cyc("lw_rd_go", 1, W_MEM_RD);
        cyc("lw_wb", 1, W_MEM_WB);

        // sw with one fetch wait state
        instr(6'h2B, 6'h00);
        cyc("sw_fetch_wait", 0, W_FETCH_WAIT);
        cyc("sw_fetch", 1, W_FETCH_RDY);
        cyc("sw_decode", 1, W_DECODE);
        cyc("sw_addr", 1, W_MEM_ADDR);
        cyc("sw_wr_wait", 0, W_MEM_WR);
        cyc("sw_wr", 1, W_MEM_WR);

        // beq taken
        instr(6'h04, 6'h00);
        bus.zero = 1'b1;
        cyc("beq_fetch", 1, W_FETCH_RDY);
        cyc("beq_decode", 1, W_DECODE);
        cyc("beq_branch", 1, W_BRANCH);
        bus.zero = 1'b0;

        // j
        instr(6'h02, 6'h00);
        cyc("j_fetch", 1, W_FETCH_RDY);
        cyc("j_decode", 1, W_DECODE);
        cyc("j_jump", 1, W_JUMP);

        // addi
        instr(6'h08, 6'h00);
        cyc("addi_fetch", 1, W_FETCH_RDY);
        cyc("addi_decode", 1, W_DECODE);
        cyc("addi_exec", 1, W_I_EXEC_ADD);
        cyc("addi_wb", 1, W_I_WB);

        // Illegal opcode
        instr(6'h3F, 6'h00);
        cyc("ill_op_fetch", 1, W_FETCH_RDY);
        cyc("ill_op_decode", 1, W_DECODE_ILL);

        // Illegal R-type funct
        instr(6'h00, 6'h00);
        cyc("ill_fn_fetch", 1, W_FETCH_RDY);
        cyc("ill_fn_decode", 1, W_DECODE);
        cyc("ill_fn_exec", 1, W_R_ILL);

        // ori
        instr(6'h0D, 6'h00);
        cyc("ori_fetch", 1, W_FETCH_RDY);
`ifdef IMM_LOGIC_EN
        cyc("ori_decode", 1, W_DECODE);
        cyc("ori_exec", 1, W_I_EXEC_ORI);
        cyc("ori_wb", 1, W_I_WB);
`else
        cyc("ori_decode_ill", 1, W_DECODE_ILL);
`endif

        // Reset mid-MEM_RD
        instr(6'h23, 6'h00);
        cyc("rst_lw_fetch", 1, W_FETCH_RDY);
        cyc("rst_lw_decode", 1, W_DECODE);
        cyc("rst_lw_addr", 1, W_MEM_ADDR);
        cyc("rst_lw_rd", 0, W_MEM_RD);
        rst_n = 1'b0;
        #1;
        chk("rst_async_zero", {12'd0, cw_obs}, 32'd0);
        @(posedge clk); #1;
        bus.mem_ready = 1'b1;
        chk("rst_held_zero", {12'd0, cw_obs}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_release_gap", {12'd0, cw_obs}, 32'd0);
        @(posedge clk); #1;
        cyc("rst_refetch", 1, W_FETCH_RDY);
        cyc("rst_redecode", 1, W_DECODE);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
